// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner arbiter for the shared snoopy bus.
// Grants wait for snoop quiescence; a watchdog flags long owners.
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_CACHES = 4,
  parameter int MAX_GRANT_CYCLES = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUMBER_OF_CACHES-1:0]         requests,
  input  logic                                snoopyBusy,
  output logic [NUMBER_OF_CACHES-1:0]         grants,
  output logic [$clog2(NUMBER_OF_CACHES)-1:0] ownerId,
  output logic                                ownerValid,
  output logic                                timeout
);

  localparam int IW = $clog2(NUMBER_OF_CACHES);
  localparam int CW = (MAX_GRANT_CYCLES < 1) ? 1
                    : $clog2(MAX_GRANT_CYCLES + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_GRANT_CYCLES);
  localparam logic [IW-1:0] LASTID = IW'(NUMBER_OF_CACHES - 1);
  localparam bit WD_EN = (MAX_GRANT_CYCLES != 0);

  typedef enum logic {
    IDLE,
    GRANTED
  } arbStateT;

  arbStateT state, stateNext;

  logic [IW-1:0] pointer, pointerNext;
  logic [CW-1:0] grantCounter, counterNext;
  logic [NUMBER_OF_CACHES-1:0] grantsNext;
  logic [IW-1:0] ownerIdNext;
  logic ownerValidNext;
  logic timeoutNext;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic found;
  int idx;

  // Circular search starting at the priority pointer.
  always_comb begin
    found  = 1'b0;
    winner = pointer;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < NUMBER_OF_CACHES; k++) begin
      idx  = (int'(pointer) + k) % NUMBER_OF_CACHES;
      cand = IW'(idx);
      if (!found && requests[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    stateNext      = state;
    pointerNext    = pointer;
    grantsNext     = grants;
    ownerIdNext    = ownerId;
    ownerValidNext = ownerValid;
    counterNext    = grantCounter;
    timeoutNext    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!snoopyBusy && found) begin
          stateNext          = GRANTED;
          grantsNext         = '0;
          grantsNext[winner] = 1'b1;
          ownerIdNext        = winner;
          ownerValidNext     = 1'b1;
          counterNext        = CW'(1);
        end
      end
      GRANTED: begin
        if (requests[ownerId]) begin
          if (grantCounter < MAXC)
            counterNext = grantCounter + 1'b1;
        end else begin
          stateNext      = IDLE;
          grantsNext     = '0;
          ownerValidNext = 1'b0;
          counterNext    = '0;
          pointerNext    = (ownerId == LASTID) ? '0
                         : ownerId + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Pulse only on the edge that first reaches the threshold.
    if (WD_EN && ownerValidNext
        && counterNext == MAXC
        && grantCounter != MAXC)
      timeoutNext = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      pointer      <= '0;
      grantCounter <= '0;
      grants       <= '0;
      ownerId      <= '0;
      ownerValid   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= stateNext;
      pointer      <= pointerNext;
      grantCounter <= counterNext;
      grants       <= grantsNext;
      ownerId      <= ownerIdNext;
      ownerValid   <= ownerValidNext;
      timeout      <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter.
// Four caches, watchdog threshold of eight grant cycles.
module tb_snoopy_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] requests;
  logic       snoopyBusy;
  logic [3:0] grants;
  logic [1:0] ownerId;
  logic       ownerValid;
  logic       timeout;

  int passes = 0;
  int total  = 0;

  snoopy_bus_arbiter #(
    .NUMBER_OF_CACHES(4),
    .MAX_GRANT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .requests(requests),
    .snoopyBusy(snoopyBusy),
    .grants(grants),
    .ownerId(ownerId),
    .ownerValid(ownerValid),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL simTimeLimit observed=expired expected=done");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chkG(input string tag, input logic [3:0] exp);
    total++;
    assert (grants === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, grants, exp);
  endtask

  task automatic chkId(input string tag, input logic [1:0] exp);
    total++;
    assert (ownerId === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, ownerId, exp);
  endtask

  task automatic chkB(input string tag, input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  logic [3:0] expG;

  initial begin
    reset      = 1'b0;
    requests   = 4'b1111;
    snoopyBusy = 1'b0;

    tick;
    chkG("rstGrants0", 4'b0000);
    chkB("rstValid0", ownerValid, 1'b0);
    chkB("rstTimeout0", timeout, 1'b0);
    tick;
    chkG("rstGrants1", 4'b0000);
    chkB("rstValid1", ownerValid, 1'b0);
    chkId("rstOwner", 2'd0);

    reset = 1'b1;
    tick;
    chkG("firstGrant", 4'b0001);
    chkId("firstOwner", 2'd0);
    chkB("firstValid", ownerValid, 1'b1);

    for (int i = 0; i < 4; i++) begin
      expG = 4'b0001 << i;
      chkG("rrGrantC1", expG);
      chkId("rrOwner", 2'(i));
      tick;
      chkG("rrGrantC2", expG);
      tick;
      chkG("rrGrantC3", expG);
      chkB("rrNoTimeout", timeout, 1'b0);
      requests = 4'b1111 & ~expG;
      tick;
      chkG("rrGap", 4'b0000);
      chkB("rrGapValid", ownerValid, 1'b0);
      chkId("rrGapOwnerKept", 2'(i));
      requests = 4'b1111;
      tick;
    end
    chkG("rrWrapTo0", 4'b0001);

    requests = 4'b0010;
    tick;
    chkG("skipRel0", 4'b0000);
    tick;
    chkG("skipGrant1", 4'b0010);
    requests = 4'b0001;
    tick;
    chkG("skipRel1", 4'b0000);
    tick;
    chkG("skipSearch230", 4'b0001);

    requests = 4'b1000;
    tick;
    chkG("wrapRel0", 4'b0000);
    tick;
    chkG("wrapGrant3", 4'b1000);
    chkId("wrapOwner3", 2'd3);
    requests = 4'b0000;
    tick;
    chkG("wrapRel3", 4'b0000);
    requests = 4'b1000;
    tick;
    chkG("wrapGrant3Again", 4'b1000);
    requests = 4'b0000;
    tick;
    chkG("wrapRel3b", 4'b0000);
    requests = 4'b1001;
    tick;
    chkG("wrapPtrAt0", 4'b0001);

    requests = 4'b0000;
    tick;
    chkG("busyRel0", 4'b0000);
    snoopyBusy = 1'b1;
    requests   = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick;
      chkG("busyBlocked", 4'b0000);
      chkB("busyNoValid", ownerValid, 1'b0);
    end
    snoopyBusy = 1'b0;
    tick;
    chkG("busyGrant2", 4'b0100);
    chkId("busyOwner2", 2'd2);

    chkB("wdTimeoutC1", timeout, 1'b0);
    snoopyBusy = 1'b1;
    for (int c = 2; c <= 12; c++) begin
      tick;
      chkG("wdHeld", 4'b0100);
      chkB("wdTimeout", timeout, c == 8);
    end
    requests = 4'b0000;
    tick;
    chkG("wdRelease", 4'b0000);
    chkB("wdRelTimeout", timeout, 1'b0);
    snoopyBusy = 1'b0;

    requests = 4'b1000;
    tick;
    chkG("midGrant3", 4'b1000);
    reset    = 1'b0;
    requests = 4'b1010;
    tick;
    chkG("midRstGrants", 4'b0000);
    chkB("midRstValid", ownerValid, 1'b0);
    chkId("midRstOwner", 2'd0);
    chkB("midRstTimeout", timeout, 1'b0);
    reset = 1'b1;
    tick;
    chkG("midRstPtr0", 4'b0010);
    chkId("midRstOwner1", 2'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/snoopy_bus_arbiter.md
Name: snoopy_bus_arbiter

Overview:
- Round-robin arbiter for the shared snoopy bus between NUMBER_OF_CACHES cache CPU controllers in the invalidate-protocol snoopy cache.
- Each CPU controller raises a request, wins a one-hot grant, and holds the bus until it drops its request.
- A new grant is never issued while any snoopy controller reports an in-flight snoop transaction (snoopyBusy), so bus handover cannot race the concurrency lock.
- A watchdog flags owners that hold the bus too long; it never revokes a grant.

Parameters:
- NUMBER_OF_CACHES, 4, number of requesters; must be >= 2.
- MAX_GRANT_CYCLES, 16, watchdog threshold in grant cycles; 0 disables the watchdog.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- requests  input  NUMBER_OF_CACHES  bus request per cache; index i = cache i.
- snoopyBusy  input  1  OR of all snoopy controllers' busy; blocks new grants.
- grants  output  NUMBER_OF_CACHES  one-hot or zero; registered.
- ownerId  output  $clog2(NUMBER_OF_CACHES)  index of current owner; registered.
- ownerValid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when the owner reaches MAX_GRANT_CYCLES.

Behaviour:
- Reset (reset==0 sampled at edge):
  - grants=0, ownerId=0, ownerValid=0, timeout=0, grantCounter=0.
  - Priority pointer=0; state=IDLE.
  - Reset overrides every other input, including mid-grant.
- States: IDLE, GRANTED.
- IDLE:
  - If snoopyBusy==0 and requests!=0 at an edge, grant the first set request searching circularly from pointer: pointer, pointer+1, ..., wrapping modulo NUMBER_OF_CACHES.
  - On that edge: grants=onehot(winner), ownerId=winner, ownerValid=1, grantCounter=1, state=GRANTED.
  - Otherwise all outputs stay 0 and state stays IDLE.
  - Latency: request sampled at edge k gives grant visible after edge k.
- GRANTED:
  - While requests[ownerId]==1: grant held; grantCounter increments, saturating at MAX_GRANT_CYCLES.
  - Other requests are ignored.
  - snoopyBusy has no effect on a grant already issued.
  - When requests[ownerId]==0 sampled:
    - grants=0, ownerValid=0 at that edge.
    - pointer=(ownerId+1) mod NUMBER_OF_CACHES, wrapping from N-1 to 0.
    - ownerId keeps its last value; state=IDLE.
  - Result: at least one all-zero grant cycle between successive owners.
- Watchdog:
  - If MAX_GRANT_CYCLES!=0, timeout=1 for exactly one cycle on the edge where grantCounter goes from MAX_GRANT_CYCLES-1 to MAX_GRANT_CYCLES while the grant is held.
  - No further pulses for the same grant; the grant is not revoked.
- Invariants:
  - grants is one-hot or zero.
  - ownerValid == |grants.
  - grants[ownerId]==ownerValid.
- Simultaneous events:
  - Owner release and another request on the same edge: only the release is processed; the new grant comes at the following edge at the earliest.
  - Pointer update and search never occur in the same cycle.
- snoopyBusy rising in the same cycle as an IDLE request: no grant that edge.

Test Plan:
- Reset: reset=0 for 2 edges with requests=4'b1111 -> grants=0, ownerValid=0, timeout=0. Release reset -> first edge with reset=1 gives grants=4'b0001, ownerId=0.
- Round-robin fairness: requests=4'b1111 held; each owner drops its request after 3 grant cycles, then re-raises it -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one grants=0 cycle between owners.
- Pointer skip and wrap:
  - Owner 1 releases, then requests=4'b0001 -> grants=4'b0001 (search 2, 3, 0).
  - Owner 3 releases with requests=4'b1000 -> grants=4'b1000, with pointer wrapped to 0.
- snoopyBusy block: snoopyBusy=1 for 5 cycles with requests=4'b0100 -> grants=0 throughout. First edge sampling snoopyBusy=0 gives grants=4'b0100.
- Watchdog with MAX_GRANT_CYCLES=8: owner 2 holds 12 cycles -> timeout=1 only in grant cycle 8, grants=4'b0100 for all 12 cycles. Release -> grants=0, timeout stays 0.
- Reset mid-grant: owner 3 granted, reset=0 for one edge -> grants=0, ownerValid=0, pointer=0. After reset release with requests=4'b1010 -> grants=4'b0010.
